riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
// - Shares the single data/instruction RAM port between the fetch unit (read-only) and the LSU (load/store).
// - Sits between the core front-end/LSU and the byte-addressed RAM; RAM read data is registered (1-cycle latency).
// - Fixed data-over-fetch priority with anti-starvation: fetch is forced a slot after MAX_DATA_STREAK back-to-back data grants.
// PARAMETERS
// - WORD_LENGTH      32  data/address width
// - MAX_DATA_STREAK  4   consecutive LSU grants allowed while if_req is pending (>=1)
// PORTS
// - clk           in   1            rising-edge clock
// - rst_n         in   1            asynchronous active-low reset
// - if_req        in   1            fetch request; addr held stable until if_gnt
// - if_addr       in   WORD_LENGTH  fetch byte address (pc)
// - if_flush      in   1            discard fetch response due next cycle (redirect)
// - if_gnt        out  1            fetch accepted this cycle (combinational)
// - if_rvalid     out  1            if_rdata valid (registered)
// - if_rdata      out  WORD_LENGTH  instruction word
// - ls_req        in   1            LSU request; fields held until ls_gnt
// - ls_we         in   1            1 = store, 0 = load
// - ls_addr       in   WORD_LENGTH  LSU byte address
// - ls_wdata      in   WORD_LENGTH  store data
// - ls_mask       in   MASK_SEL     MASK_B / MASK_H / MASK_X store width
// - ls_gnt        out  1            LSU accepted this cycle (combinational)
// - ls_rvalid     out  1            load data valid / store completed (registered)
// - ls_rdata      out  WORD_LENGTH  load data (0 on store completion)
// - ls_err        out  1            misaligned access (only with RISCV_MEM_ALIGN_CHECK_EN, else tied 0)
// - ram_addr      out  WORD_LENGTH  to RAM addr (mux of granted requester)
// - ram_we        out  1            to RAM write_en; only asserted on granted store
// - ram_wdata     out  WORD_LENGTH  to RAM wdata
// - ram_mask_sel  out  MASK_SEL     to RAM ram_mask_sel (MASK_X on fetch)
// - ram_rdata     in   WORD_LENGTH  RAM read data, valid 1 cycle after address
// BEHAVIOUR
// - Reset: if_gnt=ls_gnt=0, if_rvalid=ls_rvalid=0, rdata=0, ls_err=0, ram_we=0, streak=0, owner=NONE.
// - At most one grant per cycle; throughput 1 access/cycle, back-to-back grants allowed.
// - Grant rule: ls_req && (!if_req || streak<MAX_DATA_STREAK) -> LSU; else if_req -> fetch; else none.
// - streak: +1 on LSU grant while if_req=1 (saturating); cleared on fetch grant or when if_req=0.
// - Grant cycle N: ram_* driven from winner combinationally; owner register <= winner (IF/LS/NONE).
// - Cycle N+1: owner=IF -> if_rvalid=1, if_rdata=ram_rdata; owner=LS -> ls_rvalid=1, ls_rdata=ram_rdata (load) or 0 (store).
// - rvalid is a 1-cycle pulse; no backpressure on responses (requesters must always accept).
// - if_flush in cycle N+1 of a fetch grant suppresses that if_rvalid; flush with no fetch outstanding ignored.
// - if_flush with if_req in same cycle: new request still arbitrated normally.
// - No grants: ram_we=0, ram_addr holds last value, ram_mask_sel=MASK_X.
// - Simultaneous if_req+ls_req after reset: LSU wins (streak=0).
// - Reset mid-access: outstanding response dropped, no rvalid after rst_n deasserts.
// - Address wrap is RAM's concern; arbiter passes address unmodified.
// CONFIGURATION
// - RISCV_MEM_ALIGN_CHECK_EN defined: LSU access with MASK_H and addr[0]!=0, or MASK_X and addr[1:0]!=0,
//   is granted but ram_we forced 0; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0. Fetch with if_addr[1:0]!=0
//   handled identically on if side (if_rvalid=1, if_rdata=0); ls_err reports LSU only.
// - Undefined: no checks, ls_err tied 0, misaligned accesses passed to RAM as-is.
// TESTING
// - Reset: rst_n=0 mid-load -> no ls_rvalid after release; all outputs 0.
// - if_req only, if_addr=0x10, RAM word 0x00100193 -> if_gnt cycle N, if_rvalid+if_rdata=0x00100193 at N+1.
// - if_req+ls_req (store 0xDEADBEEF @0x40, MASK_X) -> ls_gnt first, ram_we=1; if_gnt next cycle; load @0x40 returns 0xDEADBEEF.
// - ls_req held 10 cycles + if_req held, MAX_DATA_STREAK=4 -> grant pattern LLLLF LLLLF.
// - Fetch granted at N, if_flush=1 at N+1 -> no if_rvalid; following fetch returns normally.
// - With RISCV_MEM_ALIGN_CHECK_EN: store MASK_H @0x41 -> ram_we=0, ls_rvalid=1, ls_err=1; mem unchanged.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Mask-select encoding and the bundled request/grant/RAM bus for riscv_mem_arbiter.
// The arbiter uses the slave modport; the core/RAM side uses the master modport.
package riscv_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    MASK_B = 2'b00,
    MASK_H = 2'b01,
    MASK_X = 2'b10
  } mask_sel_e;
endpackage

interface riscv_mem_arbiter_if #(
  parameter int WORD_LENGTH = 32
);
  logic                               if_req;
  logic [WORD_LENGTH-1:0]             if_addr;
  logic                               if_flush;
  logic                               if_gnt;
  logic                               if_rvalid;
  logic [WORD_LENGTH-1:0]             if_rdata;

  logic                               ls_req;
  logic                               ls_we;
  logic [WORD_LENGTH-1:0]             ls_addr;
  logic [WORD_LENGTH-1:0]             ls_wdata;
  riscv_mem_arbiter_pkg::mask_sel_e   ls_mask;
  logic                               ls_gnt;
  logic                               ls_rvalid;
  logic [WORD_LENGTH-1:0]             ls_rdata;
  logic                               ls_err;

  logic [WORD_LENGTH-1:0]             ram_addr;
  logic                               ram_we;
  logic [WORD_LENGTH-1:0]             ram_wdata;
  riscv_mem_arbiter_pkg::mask_sel_e   ram_mask_sel;
  logic [WORD_LENGTH-1:0]             ram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output ram_addr, ram_we, ram_wdata, ram_mask_sel,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_mask,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  ram_addr, ram_we, ram_wdata, ram_mask_sel,
    output ram_rdata
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/LSU arbiter for a single RAM port: data-over-fetch priority with a bounded data streak.
// Optional alignment checking is enabled by defining RISCV_MEM_ALIGN_CHECK_EN.
module riscv_mem_arbiter #(
  parameter int WORD_LENGTH     = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_mem_arbiter_if.slave       bus
);
  import riscv_mem_arbiter_pkg::*;

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_LS   = 2'b10
  } owner_e;

  owner_e                 owner_q, owner_d;
  logic [STREAK_W-1:0]    streak_q, streak_d;
  logic [WORD_LENGTH-1:0] addr_q;
  logic                   store_q, store_d;
  logic                   err_q, err_d;

  logic                   ls_win, if_win;
  logic                   ls_misalign, if_misalign;
  logic [WORD_LENGTH-1:0] addr_mux;

`ifdef RISCV_MEM_ALIGN_CHECK_EN
  assign ls_misalign = ((bus.ls_mask == MASK_H) && bus.ls_addr[0]) ||
                       ((bus.ls_mask == MASK_X) && (bus.ls_addr[1:0] != 2'b00));
  assign if_misalign = (bus.if_addr[1:0] != 2'b00);
`else
  assign ls_misalign = 1'b0;
  assign if_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      addr_q   <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_mux;
      store_q  <= store_d;
      err_q    <= err_d;
    end
  end

  // The streak only counts data grants that made a waiting fetch lose.
  always_comb begin
    ls_win   = bus.ls_req && (!bus.if_req || (streak_q < STREAK_MAX));
    if_win   = bus.if_req && !ls_win;
    owner_d  = OWN_NONE;
    streak_d = streak_q;
    store_d  = 1'b0;
    err_d    = 1'b0;
    addr_mux = addr_q;
    if (ls_win) begin
      owner_d  = OWN_LS;
      store_d  = bus.ls_we;
      err_d    = ls_misalign;
      addr_mux = bus.ls_addr;
    end else if (if_win) begin
      owner_d  = OWN_IF;
      err_d    = if_misalign;
      addr_mux = bus.if_addr;
    end
    if (!bus.if_req || if_win) begin
      streak_d = '0;
    end else if (ls_win && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  assign bus.if_gnt       = if_win;
  assign bus.ls_gnt       = ls_win;
  assign bus.ram_addr     = addr_mux;
  assign bus.ram_we       = ls_win && bus.ls_we && !ls_misalign;
  assign bus.ram_wdata    = ls_win ? bus.ls_wdata : '0;
  assign bus.ram_mask_sel = ls_win ? bus.ls_mask : MASK_X;

  // Responses are a single-cycle pulse driven from the owner captured at grant time.
  assign bus.if_rvalid = (owner_q == OWN_IF) && !bus.if_flush;
  assign bus.if_rdata  = (bus.if_rvalid && !err_q) ? bus.ram_rdata : '0;
  assign bus.ls_rvalid = (owner_q == OWN_LS);
  assign bus.ls_rdata  = (bus.ls_rvalid && !store_q && !err_q) ? bus.ram_rdata : '0;

`ifdef RISCV_MEM_ALIGN_CHECK_EN
  assign bus.ls_err = bus.ls_rvalid && err_q;
`else
  assign bus.ls_err = 1'b0;
`endif

endmodule
